// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch (IF) and MMU (DM) ports for a single shared memory,
// sequencing one transaction at a time with a watchdog abort.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_grant,
   output logic                  if_data_valid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req_valid,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_grant,
   output logic                  dm_data_valid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  timeout_err
);

   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic                  owner, owner_nxt;
   logic                  last_owner, last_owner_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
   logic                  wd_fire, pick_dm;
   logic                  mem_req_nxt, mem_we_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [DATA_WIDTH-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt, resp_data;
   logic                  if_grant_nxt, dm_grant_nxt, if_dv_nxt, dm_dv_nxt, timeout_nxt;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         owner         <= OWN_IF;
         last_owner    <= OWN_DM;
         cnt           <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         if_grant      <= 1'b0;
         dm_grant      <= 1'b0;
         if_data_valid <= 1'b0;
         dm_data_valid <= 1'b0;
         if_rdata      <= '0;
         dm_rdata      <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_nxt;
         owner         <= owner_nxt;
         last_owner    <= last_owner_nxt;
         cnt           <= cnt_nxt;
         mem_req       <= mem_req_nxt;
         mem_we        <= mem_we_nxt;
         mem_addr      <= mem_addr_nxt;
         mem_wdata     <= mem_wdata_nxt;
         if_grant      <= if_grant_nxt;
         dm_grant      <= dm_grant_nxt;
         if_data_valid <= if_dv_nxt;
         dm_data_valid <= dm_dv_nxt;
         if_rdata      <= if_rdata_nxt;
         dm_rdata      <= dm_rdata_nxt;
         timeout_err   <= timeout_nxt;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      cnt_nxt        = cnt;
      mem_req_nxt    = mem_req;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      if_grant_nxt   = 1'b0;
      dm_grant_nxt   = 1'b0;
      if_dv_nxt      = 1'b0;
      dm_dv_nxt      = 1'b0;
      if_rdata_nxt   = if_rdata;
      dm_rdata_nxt   = dm_rdata;
      timeout_nxt    = 1'b0;
      pick_dm        = dm_req_valid && (!if_req_valid || (last_owner == OWN_IF));
      resp_data      = mem_we ? '0 : mem_rdata;
      // Saturating count; the abort fires on the cycle the count would reach TIMEOUT
      cnt_inc        = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      wd_fire        = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

      case (state)
         IDLE: begin
            if (if_req_valid || dm_req_valid) begin
               owner_nxt   = pick_dm;
               mem_req_nxt = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = ISSUE;
               if (pick_dm) begin
                  mem_we_nxt    = dm_we;
                  mem_addr_nxt  = dm_addr;
                  mem_wdata_nxt = dm_wdata;
                  dm_grant_nxt  = 1'b1;
               end else begin
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = if_addr;
                  mem_wdata_nxt = '0;
                  if_grant_nxt  = 1'b1;
               end
            end
         end
         ISSUE: begin
            cnt_nxt = cnt_inc;
            if (wd_fire || mem_ready) begin
               mem_req_nxt = 1'b0;
               state_nxt   = wd_fire ? RESP : WAIT;
            end
            if (wd_fire) begin
               timeout_nxt = 1'b1;
               if (owner == OWN_DM) begin
                  dm_dv_nxt    = 1'b1;
                  dm_rdata_nxt = '0;
               end else begin
                  if_dv_nxt    = 1'b1;
                  if_rdata_nxt = '0;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt_inc;
            // A genuine response takes priority over an abort in the same cycle
            if (mem_rvalid || wd_fire) begin
               state_nxt   = RESP;
               timeout_nxt = !mem_rvalid;
               if (owner == OWN_DM) begin
                  dm_dv_nxt    = 1'b1;
                  dm_rdata_nxt = mem_rvalid ? resp_data : '0;
               end else begin
                  if_dv_nxt    = 1'b1;
                  if_rdata_nxt = mem_rvalid ? resp_data : '0;
               end
            end
         end
         RESP: begin
            last_owner_nxt = owner;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads/stores, round-robin, watchdog and reset abort.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_valid, if_grant, if_data_valid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req_valid, dm_we, dm_grant, dm_data_valid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_ready, mem_rvalid, timeout_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_grant(if_grant),
      .if_data_valid(if_data_valid), .if_rdata(if_rdata),
      .dm_req_valid(dm_req_valid), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_grant(dm_grant), .dm_data_valid(dm_data_valid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      if_req_valid = 1'b0; if_addr = '0;
      dm_req_valid = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step(); step();

      // Reset state
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_grant", 32'(if_grant), 0);
      chk("rst_dm_grant", 32'(dm_grant), 0);
      chk("rst_dv", 32'({if_data_valid, dm_data_valid}), 0);
      chk("rst_timeout", 32'(timeout_err), 0);

      // Single IF read at 0x100
      reset = 1'b0; if_req_valid = 1'b1; if_addr = 32'h100;
      step();
      chk("if1_grant", 32'(if_grant), 1);
      chk("if1_mem_req", 32'(mem_req), 1);
      chk("if1_mem_addr", mem_addr, 32'h100);
      chk("if1_mem_we", 32'(mem_we), 0);
      chk("if1_dm_grant", 32'(dm_grant), 0);
      if_req_valid = 1'b0; mem_ready = 1'b1;
      step();
      chk("if1_wait_req", 32'(mem_req), 0);
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      mem_rvalid = 1'b0;
      chk("if1_dv", 32'(if_data_valid), 1);
      chk("if1_rdata", if_rdata, 32'hDEADBEEF);
      chk("if1_dm_quiet", 32'({dm_grant, dm_data_valid}), 0);
      chk("if1_dm_rdata", dm_rdata, 0);
      step();
      chk("if1_dv_pulse", 32'(if_data_valid), 0);

      // DM store 0x1234 -> 0x40, ready held low 5 cycles
      dm_req_valid = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234;
      step();
      chk("st_grant", 32'(dm_grant), 1);
      dm_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("st_hold_req", 32'(mem_req), 1);
         chk("st_hold_we", 32'(mem_we), 1);
         chk("st_hold_addr", mem_addr, 32'h40);
         chk("st_hold_wdata", mem_wdata, 32'h1234);
         step();
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_rvalid = 1'b0;
      chk("st_dv", 32'(dm_data_valid), 1);
      chk("st_rdata", dm_rdata, 0);
      chk("st_timeout", 32'(timeout_err), 0);
      chk("st_if_rdata_kept", if_rdata, 32'hDEADBEEF);
      step();

      // Both request from reset: alternate IF, DM, IF, DM
      reset = 1'b1;
      step();
      reset = 1'b0;
      if_req_valid = 1'b1; if_addr = 32'h200;
      dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_if_grant", 32'(if_grant), 32'((i % 2) == 0));
         chk("rr_dm_grant", 32'(dm_grant), 32'((i % 2) == 1));
         chk("rr_addr", mem_addr, ((i % 2) == 0) ? 32'h200 : 32'h300);
         mem_ready = 1'b1;
         step();
         mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1000_0000 + 32'(i);
         step();
         mem_rvalid = 1'b0;
         chk("rr_if_dv", 32'(if_data_valid), 32'((i % 2) == 0));
         chk("rr_dm_dv", 32'(dm_data_valid), 32'((i % 2) == 1));
         chk("rr_rdata", ((i % 2) == 0) ? if_rdata : dm_rdata, 32'h1000_0000 + 32'(i));
         step();
      end
      if_req_valid = 1'b0; dm_req_valid = 1'b0;

      // Watchdog: DM load accepted, no rvalid ever
      dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      step();
      chk("wd_grant", 32'(dm_grant), 1);
      dm_req_valid = 1'b0; mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         chk("wd_no_dv", 32'(dm_data_valid), 0);
         chk("wd_no_err", 32'(timeout_err), 0);
         step();
      end
      chk("wd_dv", 32'(dm_data_valid), 1);
      chk("wd_rdata", dm_rdata, 0);
      chk("wd_err", 32'(timeout_err), 1);
      step();
      chk("wd_err_pulse", 32'(timeout_err), 0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      step();
      mem_rvalid = 1'b0;
      chk("wd_stale_dv", 32'({if_data_valid, dm_data_valid}), 0);
      chk("wd_stale_req", 32'(mem_req), 0);
      chk("wd_stale_rdata", dm_rdata, 0);

      // Reset mid-WAIT, then a normal DM load
      dm_req_valid = 1'b1; dm_addr = 32'h44;
      step();
      dm_req_valid = 1'b0; mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rw_mem_req", 32'(mem_req), 0);
      chk("rw_mem_addr", mem_addr, 0);
      chk("rw_dv", 32'({if_data_valid, dm_data_valid}), 0);
      chk("rw_err", 32'(timeout_err), 0);
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      step();
      mem_rvalid = 1'b0;
      chk("rw_stale_dv", 32'(dm_data_valid), 0);
      dm_req_valid = 1'b1; dm_addr = 32'h44;
      step();
      chk("rw_grant", 32'(dm_grant), 1);
      chk("rw_addr", mem_addr, 32'h44);
      dm_req_valid = 1'b0; mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      chk("rw_dv_ok", 32'(dm_data_valid), 1);
      chk("rw_rdata", dm_rdata, 32'hCAFEF00D);
      step();

      // IF holds req_valid through data_valid: a second transaction follows
      if_req_valid = 1'b1; if_addr = 32'h500;
      step();
      chk("hold_grant1", 32'(if_grant), 1);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0500;
      step();
      mem_rvalid = 1'b0;
      chk("hold_dv", 32'(if_data_valid), 1);
      step();
      chk("hold_idle_grant", 32'(if_grant), 0);
      step();
      chk("hold_grant2", 32'(if_grant), 1);
      chk("hold_req2", 32'(mem_req), 1);
      if_req_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
